// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER RV32I control FSM: sequences fetch, execute, load writeback and interrupt entry.
// Latency: non-load MEM_LAT+1 cycles, load 2*MEM_LAT+1 cycles, interrupt entry +1 cycle.
// Backpressure: none; memories are assumed to return data a fixed MEM_LAT cycles after the read enable.
module otter_cu_fsm #(
    parameter int MEM_LAT = 1,      // memory read latency, 1..4, shared by fetch and data ports
    parameter bit INTR_EN = 1'b1    // 0 removes interrupt entry entirely
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic       mie,
    input  logic [6:0] ir6to0,
    input  logic [2:0] ir14to12,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       illegal,
    output logic       rst_out,
    output logic [2:0] state
);

    // State encodings are fixed so the debug port stays compatible with existing tooling.
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_INTR  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    // Wait counter only needs to reach MEM_LAT-1; one extra code keeps MEM_LAT=1 at a legal width.
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    logic [2:0]    cur_st;
    logic [2:0]    nxt_st;
    logic [CW-1:0] cnt;
    logic          done;
    logic          take_int;

    assign done     = (cnt == CNT_LAST);
    // Interrupts are only considered on the last cycle of an instruction, where this is consulted.
    assign take_int = INTR_EN && INTR && mie;
    assign state    = cur_st;

    // State register and wait counter; the counter restarts on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_st <= ST_INIT;
            cnt    <= '0;
        end else begin
            cur_st <= nxt_st;
            if (nxt_st != cur_st) begin
                cnt <= '0;
            end else if ((cur_st == ST_FETCH) || (cur_st == ST_WB)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Next-state selection and Moore/decoder outputs from state, counter and the stable IR.
    always_comb begin
        nxt_st    = cur_st;
        PC_WE     = 1'b0;
        RF_WE     = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        memWE2    = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        illegal   = 1'b0;
        rst_out   = 1'b0;
        case (cur_st)
            ST_INIT: begin
                rst_out = 1'b1;
                nxt_st  = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1 = 1'b1;
                if (done) begin
                    nxt_st = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Every non-load retires here, so PC advances now; loads defer it to WB.
                PC_WE  = 1'b1;
                nxt_st = take_int ? ST_INTR : ST_FETCH;
                case (ir6to0)
                    OP_LOAD: begin
                        PC_WE    = 1'b0;
                        memRDEN2 = 1'b1;
                        nxt_st   = ST_WB;
                    end
                    OP_STORE: begin
                        memWE2 = 1'b1;
                    end
                    OP_BRANCH, OP_JAL: begin
                    end
                    OP_JALR, OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
                        RF_WE = 1'b1;
                    end
                    OP_SYSTEM: begin
                        if (ir14to12 == F3_CSRRW) begin
                            RF_WE  = 1'b1;
                            csr_WE = 1'b1;
                        end else if (ir14to12 == F3_MRET) begin
                            mret_exec = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcode: flag it and step over it.
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                memRDEN2 = 1'b1;
                if (done) begin
                    RF_WE  = 1'b1;
                    PC_WE  = 1'b1;
                    nxt_st = take_int ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                PC_WE     = 1'b1;
                nxt_st    = ST_FETCH;
            end
            default: begin
                // Unused encodings recover through INIT.
                nxt_st = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm across MEM_LAT=1/2/3 and INTR_EN=0.
// Latency: checks are taken 3 time units after each rising edge.
// Backpressure: not applicable; inputs are driven directly.
module tb_otter_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       INTR;
    logic       mie;
    logic [6:0] ir;
    logic [2:0] f3;

    // Output bundle per instance: {state[2:0], rst_out, illegal, mret_exec, int_taken,
    // csr_WE, memWE2, memRDEN2, memRDEN1, RF_WE, PC_WE}
    logic [12:0] o1, o2, o3, o4;

    int checks   = 0;
    int failures = 0;

    localparam logic [9:0] NONE = 10'd0;
    localparam logic [9:0] PC   = 10'd1;
    localparam logic [9:0] RF   = 10'd2;
    localparam logic [9:0] RD1  = 10'd4;
    localparam logic [9:0] RD2  = 10'd8;
    localparam logic [9:0] WE2  = 10'd16;
    localparam logic [9:0] CSR  = 10'd32;
    localparam logic [9:0] INT  = 10'd64;
    localparam logic [9:0] MRT  = 10'd128;
    localparam logic [9:0] ILL  = 10'd256;
    localparam logic [9:0] RSO  = 10'd512;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_INTR  = 3'd4;

    always #5 CLK = ~CLK;

    otter_cu_fsm #(.MEM_LAT(1), .INTR_EN(1'b1)) u1 (
        .CLK(CLK), .RST(RST), .INTR(INTR), .mie(mie), .ir6to0(ir), .ir14to12(f3),
        .PC_WE(o1[0]), .RF_WE(o1[1]), .memRDEN1(o1[2]), .memRDEN2(o1[3]), .memWE2(o1[4]),
        .csr_WE(o1[5]), .int_taken(o1[6]), .mret_exec(o1[7]), .illegal(o1[8]),
        .rst_out(o1[9]), .state(o1[12:10]));

    otter_cu_fsm #(.MEM_LAT(2), .INTR_EN(1'b1)) u2 (
        .CLK(CLK), .RST(RST), .INTR(INTR), .mie(mie), .ir6to0(ir), .ir14to12(f3),
        .PC_WE(o2[0]), .RF_WE(o2[1]), .memRDEN1(o2[2]), .memRDEN2(o2[3]), .memWE2(o2[4]),
        .csr_WE(o2[5]), .int_taken(o2[6]), .mret_exec(o2[7]), .illegal(o2[8]),
        .rst_out(o2[9]), .state(o2[12:10]));

    otter_cu_fsm #(.MEM_LAT(3), .INTR_EN(1'b1)) u3 (
        .CLK(CLK), .RST(RST), .INTR(INTR), .mie(mie), .ir6to0(ir), .ir14to12(f3),
        .PC_WE(o3[0]), .RF_WE(o3[1]), .memRDEN1(o3[2]), .memRDEN2(o3[3]), .memWE2(o3[4]),
        .csr_WE(o3[5]), .int_taken(o3[6]), .mret_exec(o3[7]), .illegal(o3[8]),
        .rst_out(o3[9]), .state(o3[12:10]));

    otter_cu_fsm #(.MEM_LAT(2), .INTR_EN(1'b0)) u4 (
        .CLK(CLK), .RST(RST), .INTR(INTR), .mie(mie), .ir6to0(ir), .ir14to12(f3),
        .PC_WE(o4[0]), .RF_WE(o4[1]), .memRDEN1(o4[2]), .memRDEN2(o4[3]), .memWE2(o4[4]),
        .csr_WE(o4[5]), .int_taken(o4[6]), .mret_exec(o4[7]), .illegal(o4[8]),
        .rst_out(o4[9]), .state(o4[12:10]));

    function automatic logic [12:0] ex(input logic [2:0] s, input logic [9:0] strb);
        return {s, strb};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    initial begin
        // ---- Reset, then ALU op at MEM_LAT=1 ----
        RST = 1'b1; INTR = 1'b0; mie = 1'b0; ir = 7'b0110011; f3 = 3'b000;
        #1;
        chk("rst_u1", o1, ex(S_INIT, RSO));
        chk("rst_u2", o2, ex(S_INIT, RSO));
        chk("rst_u3", o3, ex(S_INIT, RSO));
        step; RST = 1'b0; #1;
        chk("alu_init_hold", o1, ex(S_INIT, RSO));
        step; chk("alu_fetch", o1, ex(S_FETCH, RD1));
        step; chk("alu_exec", o1, ex(S_EXEC, PC | RF));
        step; chk("alu_fetch2", o1, ex(S_FETCH, RD1));
        step; chk("alu_exec2", o1, ex(S_EXEC, PC | RF));

        // ---- Load at MEM_LAT=3: 7 cycles ----
        RST = 1'b1; ir = 7'b0000011; #1;
        chk("ld_rst", o3, ex(S_INIT, RSO));
        step; RST = 1'b0;
        step; chk("ld_f0", o3, ex(S_FETCH, RD1));
        step; chk("ld_f1", o3, ex(S_FETCH, RD1));
        step; chk("ld_f2", o3, ex(S_FETCH, RD1));
        step; chk("ld_exec", o3, ex(S_EXEC, RD2));
        step; chk("ld_wb0", o3, ex(S_WB, RD2));
        step; chk("ld_wb1", o3, ex(S_WB, RD2));
        step; chk("ld_wb2", o3, ex(S_WB, RD2 | RF | PC));
        step; chk("ld_next_fetch", o3, ex(S_FETCH, RD1));

        // ---- Store with INTR held, mie=1 then mie=0 (MEM_LAT=1) ----
        RST = 1'b1; ir = 7'b0100011; INTR = 1'b1; mie = 1'b1; #1;
        step; RST = 1'b0;
        step; chk("st_fetch", o1, ex(S_FETCH, RD1));
        step; chk("st_exec", o1, ex(S_EXEC, WE2 | PC));
        step; chk("st_intr", o1, ex(S_INTR, INT | PC));
        step; chk("st_intr_fetch", o1, ex(S_FETCH, RD1));
        mie = 1'b0;
        step; chk("st_exec_nomie", o1, ex(S_EXEC, WE2 | PC));
        step; chk("st_nointr", o1, ex(S_FETCH, RD1));

        // ---- CSRRW then MRET; MRET cycle sees mie=1 so INTR follows ----
        ir = 7'b1110011; f3 = 3'b001;
        step; chk("csrrw_exec", o1, ex(S_EXEC, PC | RF | CSR));
        step; chk("csrrw_fetch", o1, ex(S_FETCH, RD1));
        f3 = 3'b000; mie = 1'b1;
        step; chk("mret_exec", o1, ex(S_EXEC, PC | MRT));
        step; chk("mret_intr", o1, ex(S_INTR, INT | PC));
        INTR = 1'b0;
        step; chk("mret_fetch", o1, ex(S_FETCH, RD1));

        // ---- Illegal opcodes ----
        ir = 7'b1111111;
        step; chk("ill_exec", o1, ex(S_EXEC, PC | ILL));
        step; chk("ill_fetch", o1, ex(S_FETCH, RD1));
        ir = 7'b1110011; f3 = 3'b010;
        step; chk("ill_sys_exec", o1, ex(S_EXEC, PC | ILL));
        step; chk("ill_sys_fetch", o1, ex(S_FETCH, RD1));

        // ---- Reset during WB at MEM_LAT=2, with and without interrupt support ----
        RST = 1'b1; ir = 7'b0000011; f3 = 3'b010; INTR = 1'b1; mie = 1'b1; #1;
        step; RST = 1'b0;
        step; chk("wbr_f0", o2, ex(S_FETCH, RD1));
        step; chk("wbr_f1", o2, ex(S_FETCH, RD1));
        step; chk("wbr_exec", o2, ex(S_EXEC, RD2));
        step; chk("wbr_wb0", o2, ex(S_WB, RD2));
        chk("wbr_wb0_noint", o4, ex(S_WB, RD2));
        RST = 1'b1; #1;
        chk("wbr_abort_u2", o2, ex(S_INIT, RSO));
        chk("wbr_abort_u4", o4, ex(S_INIT, RSO));
        step; RST = 1'b0; #1;
        chk("wbr_init_hold", o2, ex(S_INIT, RSO));
        step; chk("wbr_refetch0", o2, ex(S_FETCH, RD1));
        step; chk("wbr_refetch1", o4, ex(S_FETCH, RD1));
        step; chk("wbr_reexec", o2, ex(S_EXEC, RD2));
        step; chk("wbr_rewb0", o2, ex(S_WB, RD2));
        step; chk("wbr_rewb1", o2, ex(S_WB, RD2 | RF | PC));
        chk("wbr_rewb1_noint", o4, ex(S_WB, RD2 | RF | PC));
        step; chk("wbr_intr_u2", o2, ex(S_INTR, INT | PC));
        chk("wbr_nointr_u4", o4, ex(S_FETCH, RD1));
        step; chk("wbr_after_intr", o2, ex(S_FETCH, RD1));
        chk("wbr_u4_still_fetch", o4, ex(S_FETCH, RD1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multicycle control-unit state machine for the OTTER RV32I core, sequencing fetch, execute, load writeback and interrupt entry around the combinational decoder. Parametrised successor to the single-latency FSM. It adds a configurable memory read latency, machine-interrupt entry, CSRRW/MRET strobes and illegal-opcode flagging. It sits between instruction memory/IR and the PC, register file, CSR file and data-memory enables.

## Interface

Parameters
- MEM_LAT, default 1: memory read latency in cycles, legal range 1..4. Applies to both the fetch port and the data port.
- INTR_EN, default 1: 0 compiles out interrupt entry. INTR is then ignored.

Ports
- CLK  in  1  system clock. All state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- INTR  in  1  external machine interrupt request, level-sensitive.
- mie  in  1  mstatus.MIE from the CSR file.
- ir6to0  in  7  opcode of the current IR.
- ir14to12  in  3  funct3 of the current IR.
- PC_WE  out  1  PC write enable.
- RF_WE  out  1  register-file write enable.
- memRDEN1  out  1  instruction read enable.
- memRDEN2  out  1  data read enable.
- memWE2  out  1  data write enable.
- csr_WE  out  1  CSR write strobe for CSRRW.
- int_taken  out  1  interrupt entry strobe to the CSR file (save mepc, clear MIE).
- mret_exec  out  1  MRET strobe (restore MIE).
- illegal  out  1  one-cycle pulse on an unrecognised opcode in EXEC.
- rst_out  out  1  reset to the PC and register file.
- state  out  3  current state encoding, for debug.

## Operation

- States and encodings: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4. Encodings 5..7 go to INIT on the next edge.
- Wait counter `cnt` is $clog2(MEM_LAT+1) bits wide. It clears on every state entry and increments each cycle inside FETCH and WB. A state is "done" when cnt==MEM_LAT-1.
- Outputs are combinational in (state, cnt, ir6to0, ir14to12). Any output not listed for a state is 0.
- INIT: rst_out=1. Goes to FETCH on the next edge.
- FETCH: memRDEN1=1 every cycle. Goes to EXEC when done.
- EXEC, decoded by opcode:
  - LOAD 0000011: memRDEN2=1. Goes to WB.
  - STORE 0100011: memWE2=1, PC_WE=1.
  - BRANCH 1100011 and JAL 1101111: PC_WE=1.
  - JALR 1100111, OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111: PC_WE=1, RF_WE=1.
  - SYSTEM 1110011 with funct3=001 (CSRRW): PC_WE=1, RF_WE=1, csr_WE=1.
  - SYSTEM 1110011 with funct3=000 (MRET): PC_WE=1, mret_exec=1.
  - SYSTEM with any other funct3, and any other opcode: PC_WE=1, illegal=1. The instruction is skipped.
- Exit from EXEC for non-load instructions: goes to INTR if INTR_EN && INTR && mie, otherwise to FETCH.
- WB: memRDEN2=1 every cycle. On the done cycle RF_WE=1 and PC_WE=1. The exit rule is the same as EXEC.
- INTR: int_taken=1, PC_WE=1 for exactly one cycle. Goes to FETCH.
- Interrupt sampling:
  - INTR and mie are sampled only on the final cycle of an instruction: the EXEC cycle for non-loads, the done cycle of WB for loads.
  - A pulse that falls before that cycle is lost.
- MRET interaction: MRET does not itself take a pending interrupt. The mie input sampled in that same cycle governs whether INTR is entered.

## Timing

- Reset:
  - RST asserted: state=INIT immediately and cnt=0, asynchronously.
  - While in INIT, rst_out=1 and every other output is 0.
  - After RST deasserts, INIT persists for one more edge, then FETCH.
- Reset mid-instruction: aborts at once. No write strobe is asserted after RST rises.
- Instruction latency:
  - Non-load: MEM_LAT+1 cycles.
  - Load: 2*MEM_LAT+1 cycles.
  - Interrupt entry adds 1 cycle.
- MEM_LAT=1 gives the legacy timing: 2-cycle ALU ops, 3-cycle loads.
- Strobe widths:
  - PC_WE is asserted exactly one cycle per instruction and one cycle per INTR entry.
  - RF_WE, csr_WE, memWE2, mret_exec and illegal are each at most one cycle per instruction.
- The IR is stable from the cycle after FETCH completes through the end of the instruction. The decoder relies on this; the block does not latch the IR.

## Test plan

- Reset then ALU op, MEM_LAT=1, ir6to0=0110011: cycle sequence INIT→FETCH→EXEC→FETCH. Exactly 1 PC_WE and 1 RF_WE per 2 cycles. rst_out=1 only in INIT.
- Load, MEM_LAT=3, ir6to0=0000011: memRDEN1 high for 3 cycles, then EXEC with memRDEN2=1, then WB with memRDEN2 high for 3 cycles. RF_WE=PC_WE=1 only in the last WB cycle. Total 7 cycles.
- Interrupt, mie=1, INTR held high during a store: after the EXEC cycle (memWE2=1), one INTR cycle with int_taken=1 and PC_WE=1, then FETCH. With mie=0: no INTR state.
- CSRRW (1110011/001) then MRET (1110011/000): csr_WE=1 and RF_WE=1 in the first EXEC. mret_exec=1, RF_WE=0 and PC_WE=1 in the second EXEC.
- Illegal opcode 1111111: illegal=1 and PC_WE=1 for one cycle, no other strobes, back to FETCH.
- RST pulsed during WB with MEM_LAT=2: state=0 the same cycle, RF_WE never asserted. Normal fetch resumes 2 edges after RST falls. Repeat with INTR_EN=0 and INTR=1: INTR is never entered.
